// File: rtl/sobel_window_core.sv
// Sobel |Gx|+|Gy| edge core over a 3x3 window, 3-stage pipeline with frame-border suppression.
// Optional binarising threshold (port thresh) is enabled by defining SOBEL_THRESH_EN.
module sobel_window_core #(
  parameter int BITSIZE = 8,
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [BITSIZE-1:0] top_x1,
  input  logic [BITSIZE-1:0] top_x2,
  input  logic [BITSIZE-1:0] top_x3,
  input  logic [BITSIZE-1:0] mid_x1,
  input  logic [BITSIZE-1:0] mid_x2,
  input  logic [BITSIZE-1:0] mid_x3,
  input  logic [BITSIZE-1:0] bot_x1,
  input  logic [BITSIZE-1:0] bot_x2,
  input  logic [BITSIZE-1:0] bot_x3,
`ifdef SOBEL_THRESH_EN
  input  logic [BITSIZE-1:0] thresh,
`endif
  output logic [BITSIZE-1:0] out_pix,
  output logic               out_valid,
  output logic               out_sof
);

  localparam int GW = BITSIZE + 3;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [BITSIZE-1:0] PIX_ONES = {BITSIZE{1'b1}};
  localparam logic [BITSIZE-1:0] PIX_ZERO = {BITSIZE{1'b0}};

  // Weighted column/row sum a + 2b + c, zero-extended so it never wraps.
  function automatic logic [GW-1:0] tap_sum(input logic [BITSIZE-1:0] a,
                                            input logic [BITSIZE-1:0] b,
                                            input logic [BITSIZE-1:0] c);
    return GW'(a) + (GW'(b) << 1'b1) + GW'(c);
  endfunction

  function automatic logic [GW-1:0] abs_val(input logic signed [GW-1:0] v);
    logic [GW-1:0] r;
    if (v[GW-1]) begin
      r = $unsigned(-v);
    end else begin
      r = $unsigned(v);
    end
    return r;
  endfunction

`ifndef SOBEL_THRESH_EN
  localparam logic [GW-1:0] PIX_MAX = GW'(PIX_ONES);

  function automatic logic [BITSIZE-1:0] sat_pix(input logic [GW-1:0] m);
    logic [BITSIZE-1:0] r;
    if (m > PIX_MAX) begin
      r = PIX_ONES;
    end else begin
      r = m[BITSIZE-1:0];
    end
    return r;
  endfunction
`endif

  logic [CW-1:0]        col_q, col_d, cur_col;
  logic [RW-1:0]        row_q, row_d, cur_row;
  logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
  logic                 border1_q, border1_d, sof1_q, sof1_d, v1_q, v1_d;
  logic [GW-1:0]        mag_q, mag_d;
  logic                 border2_q, border2_d, sof2_q, sof2_d, v2_q, v2_d;
  logic [BITSIZE-1:0]   pix_q, pix_d;
  logic                 valid_q, valid_d, osof_q, osof_d;
  logic                 unused_taps;

  assign unused_taps = ^mid_x2;

  // Window-centre position and stage-1 gradients; in_sof re-anchors the beat at (0,0).
  always_comb begin
    cur_col   = col_q;
    cur_row   = row_q;
    col_d     = col_q;
    row_d     = row_q;
    gx_d      = gx_q;
    gy_d      = gy_q;
    border1_d = border1_q;
    sof1_d    = 1'b0;
    v1_d      = in_valid;
    if (in_sof) begin
      cur_col = {CW{1'b0}};
      cur_row = {RW{1'b0}};
    end else begin
      cur_col = col_q;
      cur_row = row_q;
    end
    if (in_valid) begin
      if (cur_col == COL_LAST) begin
        col_d = {CW{1'b0}};
        if (cur_row == ROW_LAST) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = cur_row + RW'(1'b1);
        end
      end else begin
        col_d = cur_col + CW'(1'b1);
        row_d = cur_row;
      end
      gx_d = $signed(tap_sum(top_x3, mid_x3, bot_x3) - tap_sum(top_x1, mid_x1, bot_x1));
      gy_d = $signed(tap_sum(bot_x1, bot_x2, bot_x3) - tap_sum(top_x1, top_x2, top_x3));
      border1_d = (cur_col == {CW{1'b0}}) || (cur_col == COL_LAST) ||
                  (cur_row == {RW{1'b0}}) || (cur_row == ROW_LAST);
      sof1_d = in_sof;
    end else begin
      col_d     = col_q;
      row_d     = row_q;
      gx_d      = gx_q;
      gy_d      = gy_q;
      border1_d = border1_q;
      sof1_d    = 1'b0;
    end
  end

  // Stage 2: magnitude is GW bits wide so the +/-1020 extremes sum without overflow.
  always_comb begin
    mag_d     = abs_val(gx_q) + abs_val(gy_q);
    border2_d = border1_q;
    sof2_d    = sof1_q & v1_q;
    v2_d      = v1_q;
  end

  // Stage 3: border suppression, then saturation or threshold; pixel holds across bubbles.
  always_comb begin
    pix_d   = pix_q;
    valid_d = v2_q;
    osof_d  = v2_q & sof2_q;
    if (v2_q) begin
      if (border2_q) begin
        pix_d = PIX_ZERO;
      end else begin
`ifdef SOBEL_THRESH_EN
        if (mag_q >= GW'(thresh)) begin
          pix_d = PIX_ONES;
        end else begin
          pix_d = PIX_ZERO;
        end
`else
        pix_d = sat_pix(mag_q);
`endif
      end
    end else begin
      pix_d = pix_q;
    end
  end

  // Pipeline and counter registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= {CW{1'b0}};
      row_q     <= {RW{1'b0}};
      gx_q      <= {GW{1'b0}};
      gy_q      <= {GW{1'b0}};
      border1_q <= 1'b0;
      sof1_q    <= 1'b0;
      v1_q      <= 1'b0;
      mag_q     <= {GW{1'b0}};
      border2_q <= 1'b0;
      sof2_q    <= 1'b0;
      v2_q      <= 1'b0;
      pix_q     <= PIX_ZERO;
      valid_q   <= 1'b0;
      osof_q    <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      border1_q <= border1_d;
      sof1_q    <= sof1_d;
      v1_q      <= v1_d;
      mag_q     <= mag_d;
      border2_q <= border2_d;
      sof2_q    <= sof2_d;
      v2_q      <= v2_d;
      pix_q     <= pix_d;
      valid_q   <= valid_d;
      osof_q    <= osof_d;
    end
  end

  assign out_pix   = pix_q;
  assign out_valid = valid_q;
  assign out_sof   = osof_q;

endmodule
